soc_param_gpio_pio: RTL

//  Parametrised Avalon-MM GPIO. Successor to the fixed 16-bit output-only hex/LED PIO.

---
 rtl/soc_pio_pkg.sv | 19 +
 rtl/soc_pio_sync.sv | 25 ++
 rtl/soc_param_gpio_pio.sv | 113 +++++++++++
 3 files changed

// File: rtl/soc_pio_pkg.sv
// Shared encodings for the parametrised GPIO: register word addresses,
// edge-detect selection and interrupt source selection.
package soc_pio_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_DIR    = 3'd1;
  localparam logic [2:0] REG_MASK   = 3'd2;
  localparam logic [2:0] REG_EDGE   = 3'd3;
  localparam logic [2:0] REG_OUTSET = 3'd4;
  localparam logic [2:0] REG_OUTCLR = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/soc_pio_sync.sv
// Multi-flop synchroniser bringing asynchronous pin levels into the clk domain.
module soc_pio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/soc_param_gpio_pio.sv
// Parametrised Avalon-MM GPIO slave: per-bit direction, synchronised inputs,
// atomic set/clear, edge capture and a maskable interrupt.
module soc_param_gpio_pio
  import soc_pio_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               IRQ_TYPE    = IRQ_EDGE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out, dir, mask, edge_cap;
  logic [WIDTH-1:0] in_sync, prev, wd;
  logic [WIDTH-1:0] rise, fall, edge_det, cap_set, w1c, rd_word;
  logic [2:0]       prime_cnt;
  logic             primed, wr;

  assign wr     = chipselect & ~write_n;
  assign wd     = writedata[WIDTH-1:0];
  assign primed = (prime_cnt == PRIME_MAX);

  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_wd_hi;
      assign unused_wd_hi = |writedata[31:WIDTH];
    end
  endgenerate

  soc_pio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (in_sync)
  );

  assign rise = in_sync & ~prev;
  assign fall = ~in_sync & prev;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_det = fall;
      EDGE_ANY:  edge_det = rise | fall;
      default:   edge_det = rise;
    endcase
  end

  // Edges are ignored until the sync chain has flushed its all-zero reset contents
  assign cap_set = edge_det & ~dir & {WIDTH{primed}};
  assign w1c     = (wr && address == REG_EDGE) ? wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= RESET_VALUE;
      dir       <= DIR_RESET;
      mask      <= '0;
      edge_cap  <= '0;
      prev      <= '0;
      prime_cnt <= '0;
    end else begin
      prev <= in_sync;
      if (!primed) prime_cnt <= prime_cnt + 3'd1;
      if (wr) begin
        case (address)
          REG_DATA:   data_out <= wd;
          REG_DIR:    dir      <= wd;
          REG_MASK:   mask     <= wd;
          REG_OUTSET: data_out <= data_out | wd;
          REG_OUTCLR: data_out <= data_out & ~wd;
          default:    ;
        endcase
      end
      edge_cap <= (edge_cap & ~w1c) | cap_set;
    end
  end

  always_comb begin
    case (address)
      REG_DATA: rd_word = (data_out & dir) | (in_sync & ~dir);
      REG_DIR:  rd_word = dir;
      REG_MASK: rd_word = mask;
      REG_EDGE: rd_word = edge_cap;
      default:  rd_word = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd_word;
  end

  always_comb begin
    irq = 1'b0;
    if (IRQ_TYPE == IRQ_LEVEL)     irq = |(in_sync & ~dir & mask);
    else if (IRQ_TYPE == IRQ_EDGE) irq = |(edge_cap & mask);
  end

  assign out_port = data_out;
  assign oe       = dir;

endmodule
